// File: rtl/histo_readout_pkg.sv
// Shared histogram readout definitions: default geometry, read latency, buffer depth
// and the sweep controller state encoding.
package histo_readout_pkg;

  localparam int GRAY_W_DEF     = 8;
  localparam int COUNT_W_DEF    = 20;
  localparam int READ_LAT_DEF   = 3;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/histo_readout_if.sv
// Record stream from the histogram readout to its consumer (valid/ready handshake).
interface histo_readout_if
  import histo_readout_pkg::*;
#(
  parameter int GRAY_W  = GRAY_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) ();

  logic               oValid;
  logic               iReady;
  logic [GRAY_W-1:0]  oGray;
  logic [COUNT_W-1:0] oHisto;
  logic [COUNT_W-1:0] oCum;
  logic               oLast;

  modport master (output oValid, oGray, oHisto, oCum, oLast, input iReady);
  modport slave  (input oValid, oGray, oHisto, oCum, oLast, output iReady);

endinterface

// File: rtl/histo_readout_fifo.sv
// Small synchronous FIFO holding readout records; push and pop may coincide even when full.
module histo_readout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iPush,
  input  logic [WIDTH-1:0]           iData,
  input  logic                       iPop,
  output logic [WIDTH-1:0]           oData,
  output logic [$clog2(DEPTH+1)-1:0] oCount
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [CNT_W-1:0] count_r;
  logic             doPush_s;
  logic             doPop_s;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      nextPtr = {PTR_W{1'b0}};
    end else begin
      nextPtr = ptr + PTR_W'(1);
    end
  endfunction

  assign doPop_s  = iPop && (count_r != {CNT_W{1'b0}});
  assign doPush_s = iPush && ((count_r != CNT_FULL) || doPop_s);
  assign oData    = mem_r[rdPtr_r];
  assign oCount   = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wrPtr_r <= {PTR_W{1'b0}};
      rdPtr_r <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (doPush_s) begin
        mem_r[wrPtr_r] <= iData;
        wrPtr_r        <= nextPtr(wrPtr_r);
      end
      if (doPop_s) begin
        rdPtr_r <= nextPtr(rdPtr_r);
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/histo_readout.sv
// Sweeps every histogram bin after iHistDone rises, streams {gray, count, cum} records
// under a credit limit, and reports the peak bin plus a sum-vs-cumulative check.
module histo_readout
  import histo_readout_pkg::*;
#(
  parameter int GRAY_W     = GRAY_W_DEF,
  parameter int COUNT_W    = COUNT_W_DEF,
  parameter int READ_LAT   = READ_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iHistDone,
  output logic [GRAY_W-1:0]  oReadGray,
  input  logic [COUNT_W-1:0] iGrayHisto,
  input  logic [COUNT_W-1:0] iGrayCumHisto,
  histo_readout_if.master    rec,
  output logic               oBusy,
  output logic               oSweepDone,
  output logic [GRAY_W-1:0]  oPeakGray,
  output logic [COUNT_W-1:0] oPeakCount,
  output logic               oMismatch
);

  localparam int REC_W = GRAY_W + 2 * COUNT_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [GRAY_W-1:0] LAST_GRAY = {GRAY_W{1'b1}};

  state_e              state_r;
  state_e              nextState_s;
  logic                histDone_r;
  logic                armed_r;
  logic                rise_s;
  logic                sweepStart_s;
  logic                issue_s;
  logic                drained_s;
  int                  inFlight_s;
  logic [GRAY_W-1:0]   addrCnt_r;
  logic [GRAY_W-1:0]   readGray_r;
  logic [READ_LAT-1:0] pipeValid_r;
  logic [GRAY_W-1:0]   pipeGray_r [READ_LAT];
  logic                push_s;
  logic                pop_s;
  logic [REC_W-1:0]    pushData_s;
  logic [REC_W-1:0]    headData_s;
  logic [CNT_W-1:0]    fifoCount_s;
  logic [COUNT_W-1:0]  sum_r;
  logic [COUNT_W-1:0]  lastCum_r;
  logic [COUNT_W-1:0]  runPeakCount_r;
  logic [GRAY_W-1:0]   runPeakGray_r;
  logic [COUNT_W-1:0]  peakCount_r;
  logic [GRAY_W-1:0]   peakGray_r;
  logic                mismatch_r;
  logic                busy_r;
  logic                sweepDone_r;

  // armed_r blocks a start when iHistDone is already high as reset releases
  assign rise_s       = armed_r && iHistDone && !histDone_r;
  assign sweepStart_s = (state_r == IDLE) && rise_s;
  assign drained_s    = (fifoCount_s == {CNT_W{1'b0}}) && (pipeValid_r == {READ_LAT{1'b0}});
  assign push_s       = pipeValid_r[READ_LAT-1];
  assign pushData_s   = {pipeGray_r[READ_LAT-1], iGrayHisto, iGrayCumHisto};

  assign rec.oValid = (fifoCount_s != {CNT_W{1'b0}});
  assign {rec.oGray, rec.oHisto, rec.oCum} = headData_s;
  assign rec.oLast  = rec.oValid && (rec.oGray == LAST_GRAY);
  assign pop_s      = rec.oValid && rec.iReady;

  assign oReadGray  = readGray_r;
  assign oBusy      = busy_r;
  assign oSweepDone = sweepDone_r;
  assign oPeakGray  = peakGray_r;
  assign oPeakCount = peakCount_r;
  assign oMismatch  = mismatch_r;

  // Next state and address issue under the credit limit
  always_comb begin
    nextState_s = state_r;
    issue_s     = 1'b0;
    inFlight_s  = 0;
    for (int i = 0; i < READ_LAT; i++) begin
      inFlight_s = inFlight_s + int'(pipeValid_r[i]);
    end
    case (state_r)
      IDLE: begin
        if (rise_s) nextState_s = SWEEP;
        else        nextState_s = IDLE;
      end
      SWEEP: begin
        if ((int'(fifoCount_s) + inFlight_s) < FIFO_DEPTH) begin
          issue_s = 1'b1;
          if (addrCnt_r == LAST_GRAY) nextState_s = DRAIN;
          else                        nextState_s = SWEEP;
        end else begin
          nextState_s = SWEEP;
        end
      end
      DRAIN: begin
        if (drained_s) nextState_s = DONE;
        else           nextState_s = DRAIN;
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register and iHistDone edge detector
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r    <= IDLE;
      histDone_r <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      histDone_r <= iHistDone;
      armed_r    <= 1'b1;
    end
  end

  // Read address and in-flight tracking; data lands READ_LAT cycles after issue
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      addrCnt_r   <= {GRAY_W{1'b0}};
      readGray_r  <= {GRAY_W{1'b0}};
      pipeValid_r <= {READ_LAT{1'b0}};
      for (int i = 0; i < READ_LAT; i++) begin
        pipeGray_r[i] <= {GRAY_W{1'b0}};
      end
    end else begin
      if (issue_s) begin
        readGray_r <= addrCnt_r;
        addrCnt_r  <= addrCnt_r + GRAY_W'(1);
      end
      pipeValid_r[0] <= issue_s;
      pipeGray_r[0]  <= addrCnt_r;
      for (int i = 1; i < READ_LAT; i++) begin
        pipeValid_r[i] <= pipeValid_r[i-1];
        pipeGray_r[i]  <= pipeGray_r[i-1];
      end
    end
  end

  histo_readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) uFifo (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iPush  (push_s),
    .iData  (pushData_s),
    .iPop   (pop_s),
    .oData  (headData_s),
    .oCount (fifoCount_s)
  );

  // Running sum and peak over accepted records; strict compare keeps the lowest gray on ties
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sum_r          <= {COUNT_W{1'b0}};
      lastCum_r      <= {COUNT_W{1'b0}};
      runPeakCount_r <= {COUNT_W{1'b0}};
      runPeakGray_r  <= {GRAY_W{1'b0}};
    end else if (sweepStart_s) begin
      sum_r          <= {COUNT_W{1'b0}};
      runPeakCount_r <= {COUNT_W{1'b0}};
      runPeakGray_r  <= {GRAY_W{1'b0}};
    end else if (pop_s) begin
      sum_r <= sum_r + rec.oHisto;
      if (rec.oHisto > runPeakCount_r) begin
        runPeakCount_r <= rec.oHisto;
        runPeakGray_r  <= rec.oGray;
      end
      if (rec.oLast) begin
        lastCum_r <= rec.oCum;
      end
    end
  end

  // Status flags and sweep results, published together with the done pulse
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      busy_r      <= 1'b0;
      sweepDone_r <= 1'b0;
      peakGray_r  <= {GRAY_W{1'b0}};
      peakCount_r <= {COUNT_W{1'b0}};
      mismatch_r  <= 1'b0;
    end else begin
      busy_r      <= (nextState_s == SWEEP) || (nextState_s == DRAIN);
      sweepDone_r <= (nextState_s == DONE);
      if (nextState_s == DONE) begin
        peakGray_r  <= runPeakGray_r;
        peakCount_r <= runPeakCount_r;
        mismatch_r  <= (sum_r != lastCum_r);
      end
    end
  end

endmodule

// File: tb/tb_histo_readout.sv
// Bench for histo_readout: behavioural bin memory with READ_LAT latency, directed and
// randomized sweeps, every record and sweep result compared with a reference model.
module tb_histo_readout;

  localparam int GRAY_W     = 8;
  localparam int COUNT_W    = 20;
  localparam int READ_LAT   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int NBINS      = 1 << GRAY_W;
  localparam int CMASK      = (1 << COUNT_W) - 1;

  logic               iClk      = 1'b0;
  logic               iRst_n    = 1'b1;
  logic               iHistDone = 1'b0;
  logic [GRAY_W-1:0]  oReadGray;
  logic [COUNT_W-1:0] iGrayHisto;
  logic [COUNT_W-1:0] iGrayCumHisto;
  logic               oBusy;
  logic               oSweepDone;
  logic [GRAY_W-1:0]  oPeakGray;
  logic [COUNT_W-1:0] oPeakCount;
  logic               oMismatch;

  histo_readout_if #(.GRAY_W(GRAY_W), .COUNT_W(COUNT_W)) rec ();

  histo_readout #(
    .GRAY_W(GRAY_W), .COUNT_W(COUNT_W), .READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .iHistDone     (iHistDone),
    .oReadGray     (oReadGray),
    .iGrayHisto    (iGrayHisto),
    .iGrayCumHisto (iGrayCumHisto),
    .rec           (rec),
    .oBusy         (oBusy),
    .oSweepDone    (oSweepDone),
    .oPeakGray     (oPeakGray),
    .oPeakCount    (oPeakCount),
    .oMismatch     (oMismatch)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nPass   = 0;
  int histMem [NBINS];
  int cumMem  [NBINS];
  logic [GRAY_W-1:0] rdQ [READ_LAT-1];

  // Bin memory: returns the counts for the address presented READ_LAT cycles earlier
  always @(posedge iClk) begin
    rdQ[0] <= oReadGray;
    for (int i = 1; i < READ_LAT - 1; i++) rdQ[i] <= rdQ[i-1];
  end
  assign iGrayHisto    = COUNT_W'(histMem[rdQ[READ_LAT-2]]);
  assign iGrayCumHisto = COUNT_W'(cumMem[rdQ[READ_LAT-2]]);

  task automatic checkEq(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model of one sweep's results
  int expPeakGray, expPeakCount, expMis;
  task automatic setExpect();
    int sum;
    sum = 0;
    expPeakGray  = 0;
    expPeakCount = 0;
    for (int g = 0; g < NBINS; g++) begin
      sum = (sum + histMem[g]) & CMASK;
      if (histMem[g] > expPeakCount) begin
        expPeakCount = histMem[g];
        expPeakGray  = g;
      end
    end
    expMis = (sum != cumMem[NBINS-1]) ? 1 : 0;
  endtask

  task automatic fillFlat();
    for (int g = 0; g < NBINS; g++) begin
      histMem[g] = 1200;
      cumMem[g]  = 1200 * (g + 1);
    end
  endtask

  task automatic fillSpike();
    for (int g = 0; g < NBINS; g++) begin
      histMem[g] = (g == 77) ? 307200 : 0;
      cumMem[g]  = (g >= 77) ? 307200 : 0;
    end
  endtask

  task automatic fillRandom(input int maxVal);
    int run;
    run = 0;
    for (int g = 0; g < NBINS; g++) begin
      histMem[g] = int'($urandom_range(0, maxVal));
      run = (run + histMem[g]) & CMASK;
      cumMem[g] = run;
    end
  endtask

  // Ready pattern: 0 always, 1 one-of-three, 2 stalled, 3 random
  int readyMode = 0;
  initial begin
    int cyc;
    cyc = 0;
    rec.iReady = 1'b1;
    forever begin
      @(posedge iClk);
      #2;
      cyc++;
      case (readyMode)
        0:       rec.iReady = 1'b1;
        1:       rec.iReady = (cyc % 3 == 0);
        2:       rec.iReady = 1'b0;
        default: rec.iReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Record scoreboard: order, contents, hold stability, credit limit, sweep results
  int expIdx = 0;
  int doneCount = 0;
  bit holdPend = 1'b0;
  int holdG, holdH, holdC;
  always @(negedge iClk) begin
    if (!iRst_n) begin
      expIdx   = 0;
      holdPend = 1'b0;
    end else begin
      if (holdPend) begin
        checkEq("hold_valid", int'(rec.oValid), 1);
        checkEq("hold_gray", int'(rec.oGray), holdG);
        checkEq("hold_histo", int'(rec.oHisto), holdH);
        checkEq("hold_cum", int'(rec.oCum), holdC);
      end
      holdPend = 1'b0;
      if (rec.oValid && rec.iReady) begin
        if (expIdx < NBINS) begin
          checkEq("rec_gray", int'(rec.oGray), expIdx);
          checkEq("rec_histo", int'(rec.oHisto), histMem[expIdx]);
          checkEq("rec_cum", int'(rec.oCum), cumMem[expIdx]);
          checkEq("rec_last", int'(rec.oLast), (expIdx == NBINS - 1) ? 1 : 0);
        end else begin
          checkEq("extra_record", expIdx, NBINS - 1);
        end
        expIdx++;
      end else if (rec.oValid) begin
        holdPend = 1'b1;
        holdG = int'(rec.oGray);
        holdH = int'(rec.oHisto);
        holdC = int'(rec.oCum);
      end
      if (oBusy && expIdx > 0)
        checkEq("credit_limit", int'((int'(oReadGray) + 1 - expIdx) <= FIFO_DEPTH), 1);
      if (oSweepDone) begin
        doneCount++;
        checkEq("sweep_records", expIdx, NBINS);
        checkEq("peak_gray", int'(oPeakGray), expPeakGray);
        checkEq("peak_count", int'(oPeakCount), expPeakCount);
        checkEq("mismatch", int'(oMismatch), expMis);
        checkEq("busy_at_done", int'(oBusy), 0);
        expIdx = 0;
      end
    end
  end

  int doneStart = 0;
  task automatic startSweep();
    setExpect();
    doneStart = doneCount;
    @(negedge iClk);
    iHistDone = 1'b1;
  endtask

  task automatic waitDone();
    int t;
    t = 0;
    while (doneCount == doneStart && t < 8000) begin
      @(posedge iClk);
      t++;
    end
    checkEq("sweep_completes", int'(doneCount != doneStart), 1);
  endtask

  task automatic finishSweep();
    waitDone();
    @(negedge iClk);
    iHistDone = 1'b0;
    repeat (3) @(negedge iClk);
  endtask

  task automatic waitAccepted(input int n);
    int t;
    t = 0;
    while (expIdx < n && t < 4000) begin
      @(negedge iClk);
      t++;
    end
    checkEq("reach_record", int'(expIdx >= n), 1);
  endtask

  initial begin
    int lat;
    int a0;
    fillFlat();
    #3 iRst_n = 1'b0;
    #1;
    checkEq("rst_valid", int'(rec.oValid), 0);
    checkEq("rst_busy", int'(oBusy), 0);
    checkEq("rst_readgray", int'(oReadGray), 0);
    checkEq("rst_gray", int'(rec.oGray), 0);
    checkEq("rst_last", int'(rec.oLast), 0);
    checkEq("rst_done", int'(oSweepDone), 0);
    checkEq("rst_peak", int'(oPeakCount), 0);
    checkEq("rst_mismatch", int'(oMismatch), 0);
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    repeat (3) @(negedge iClk);

    // Flat histogram, first-record latency
    readyMode = 0;
    startSweep();
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge iClk);
      #1;
      if (rec.oValid && lat == 0) lat = n;
      if (n == 1) checkEq("busy_after_edge", int'(oBusy), 1);
    end
    checkEq("first_latency", lat, READ_LAT + 2);
    finishSweep();

    // Single spike with one-of-three ready; previous results held meanwhile
    fillSpike();
    readyMode = 1;
    startSweep();
    repeat (20) @(posedge iClk);
    #1 checkEq("peak_held", int'(oPeakCount), 1200);
    finishSweep();

    // Forced bin-255 cumulative error
    fillFlat();
    cumMem[NBINS-1] = 307199;
    readyMode = 0;
    startSweep();
    finishSweep();

    // Long stall mid-sweep
    fillRandom(5000);
    readyMode = 0;
    startSweep();
    waitAccepted(60);
    readyMode = 2;
    repeat (10) @(posedge iClk);
    #1 a0 = int'(oReadGray);
    repeat (40) @(posedge iClk);
    #1;
    checkEq("stall_addr", int'(oReadGray), a0);
    checkEq("stall_outstanding", int'(oReadGray) + 1 - expIdx, FIFO_DEPTH);
    readyMode = 0;
    finishSweep();

    // Reset at record 100, no start on release with iHistDone high, then fresh sweep
    fillRandom(1000);
    readyMode = 3;
    startSweep();
    waitAccepted(100);
    @(posedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    checkEq("midrst_valid", int'(rec.oValid), 0);
    checkEq("midrst_busy", int'(oBusy), 0);
    checkEq("midrst_readgray", int'(oReadGray), 0);
    checkEq("midrst_peakgray", int'(oPeakGray), 0);
    checkEq("midrst_cum", int'(rec.oCum), 0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    repeat (10) @(posedge iClk);
    #1;
    checkEq("no_start_on_release", int'(oBusy), 0);
    checkEq("no_valid_on_release", int'(rec.oValid), 0);
    checkEq("aborted_no_done", doneCount, doneStart);
    @(negedge iClk);
    iHistDone = 1'b0;
    repeat (2) @(negedge iClk);
    startSweep();
    finishSweep();

    // Second edge during SWEEP is ignored
    fillRandom(15);
    readyMode = 3;
    startSweep();
    waitAccepted(30);
    @(negedge iClk);
    iHistDone = 1'b0;
    repeat (2) @(negedge iClk);
    iHistDone = 1'b1;
    waitDone();
    repeat (400) @(negedge iClk);
    checkEq("single_done", doneCount - doneStart, 1);
    checkEq("no_restart", int'(oBusy), 0);
    iHistDone = 1'b0;
    repeat (3) @(negedge iClk);

    // Randomized sweeps, including sums that wrap the count width
    for (int k = 0; k < 2; k++) begin
      fillRandom((k == 0) ? 20 : CMASK);
      readyMode = 3;
      startSweep();
      finishSweep();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
